ilv_pingpong_ctrl: RTL and testbench

// - Controller/scheduler for the 2-bank (A/B) ping-pong bit interleaver memory in the WiMAX PHY TX chain.
// - Sits between the randomizer/FEC bit stream and the modulator mapper.
// - Generates permuted write addresses, sequential read addresses and bank ownership.
// - Provides a 2-entry output skid so the 1-cycle memory read latency never drops or duplicates bits.

---
 rtl/ilv_pkg.sv | 20 ++
 rtl/ilv_skid2.sv | 45 ++++
 rtl/ilv_pingpong_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ilv_pingpong_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ilv_pkg.sv
// Shared constants, bank state type and golden write-address permutation for the
// WiMAX ping-pong bit interleaver.
package ilv_pkg;

  localparam int NCBPS_QPSK = 192;
  localparam int NCOL       = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // First 802.16 permutation: row-wise write into a NCOL-column array
  function automatic int ilv_waddr(input int k);
    return (NCBPS_QPSK / NCOL) * (k % NCOL) + k / NCOL;
  endfunction

endpackage

// File: rtl/ilv_skid2.sv
// Two-entry 1-bit fall-through skid: an empty buffer passes i_dat straight to o_dat,
// so data is visible the cycle it arrives; o_cnt exposes occupancy for read credit.
module ilv_skid2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vld,
  input  logic       i_dat,
  output logic       o_vld,
  output logic       o_dat,
  input  logic       i_rdy,
  output logic [1:0] o_cnt
);

  logic [1:0] r_cnt;
  logic [1:0] r_mem;
  logic       r_head;
  logic       w_has;
  logic       w_pop;
  logic       w_deq;
  logic       w_store;
  logic       w_tail;

  assign w_has   = (r_cnt != 2'd0);
  assign o_vld   = w_has | i_vld;
  assign o_dat   = w_has ? r_mem[r_head] : i_dat;
  assign w_pop   = o_vld & i_rdy;
  assign w_deq   = w_pop & w_has;
  // A bit arriving into an empty buffer that is popped at once never gets stored
  assign w_store = i_vld & ~(w_pop & ~w_has);
  assign w_tail  = r_head ^ r_cnt[0];
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_mem  <= 2'b00;
      r_head <= 1'b0;
    end else begin
      if (w_store) r_mem[w_tail] <= i_dat;
      if (w_deq) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, w_store} - {1'b0, w_deq};
    end
  end

endmodule

// File: rtl/ilv_pingpong_ctrl.sv
// Ping-pong interleaver bank scheduler: last write to out_valid is 2 cycles; in_ready drops while
// both banks are busy, reads stall on out_ready via the skid. ILV_STATS_EN adds blk_cnt/stall_cnt.
module ilv_pingpong_ctrl #(
  parameter int NCBPS  = ilv_pkg::NCBPS_QPSK,
  parameter int NCOL   = ilv_pkg::NCOL,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_wbank,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_wdata,
  output logic              mem_re,
  output logic              mem_rbank,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_rdata,
  output logic              out_valid,
  output logic              out_data,
  input  logic              out_ready
`ifdef ILV_STATS_EN
  ,
  output logic [15:0]       blk_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  import ilv_pkg::*;

  localparam int                CW       = $clog2(NCOL);
  localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(NCBPS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(NCBPS / NCOL);
  localparam logic [CW-1:0]     LAST_R   = CW'(NCOL - 1);

  bank_state_t       r_st [2];
  logic              r_run;
  logic              r_wbank;
  logic              r_rbank;
  logic              r_re_d;
  logic [ADDR_W-1:0] r_wk;
  logic [ADDR_W-1:0] r_wcol;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_rk;
  logic [CW-1:0]     r_wrow;

  bank_state_t       w_wbank_st;
  bank_state_t       w_rbank_st;
  logic              w_wr_open;
  logic              w_rd_avail;
  logic              w_we;
  logic              w_re;
  logic              w_wlast;
  logic              w_rlast;
  logic [1:0]        w_skid_cnt;

  assign w_wbank_st = r_st[r_wbank];
  assign w_rbank_st = r_st[r_rbank];

  assign w_wr_open = (w_wbank_st == BANK_EMPTY) || (w_wbank_st == BANK_FILLING);
  assign in_ready  = r_run & w_wr_open;
  assign w_we      = in_valid & in_ready;
  assign w_wlast   = (r_wk == LAST_K);

  assign mem_we    = w_we;
  assign mem_wbank = r_wbank;
  assign mem_waddr = r_waddr;
  assign mem_wdata = in_data;

  // Issue a read only if the skid can still hold its data after the read already in flight lands
  assign w_rd_avail = (w_rbank_st == BANK_FULL) || (w_rbank_st == BANK_DRAINING);
  assign w_re       = w_rd_avail & (({1'b0, w_skid_cnt} + {2'b00, r_re_d}) < 3'd2);
  assign w_rlast    = (r_rk == LAST_K);

  assign mem_re    = w_re;
  assign mem_rbank = r_rbank;
  assign mem_raddr = r_rk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_wbank <= 1'b0;
      r_wk    <= '0;
      r_wrow  <= '0;
      r_wcol  <= '0;
      r_waddr <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_we) begin
        if (w_wlast) begin
          r_wbank <= ~r_wbank;
          r_wk    <= '0;
          r_wrow  <= '0;
          r_wcol  <= '0;
          r_waddr <= '0;
        end else begin
          r_wk <= r_wk + 1'b1;
          if (r_wrow == LAST_R) begin
            r_wrow  <= '0;
            r_wcol  <= r_wcol + 1'b1;
            r_waddr <= r_wcol + 1'b1;
          end else begin
            r_wrow  <= r_wrow + 1'b1;
            r_waddr <= r_waddr + ROW_STEP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbank <= 1'b0;
      r_rk    <= '0;
      r_re_d  <= 1'b0;
    end else begin
      r_re_d <= w_re;
      if (w_re) begin
        if (w_rlast) begin
          r_rk    <= '0;
          r_rbank <= ~r_rbank;
        end else begin
          r_rk <= r_rk + 1'b1;
        end
      end
    end
  end

  // Writer only touches an EMPTY/FILLING bank, reader only a FULL/DRAINING one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st[0] <= BANK_EMPTY;
      r_st[1] <= BANK_EMPTY;
    end else begin
      if (w_we) r_st[r_wbank] <= w_wlast ? BANK_FULL : BANK_FILLING;
      if (w_re) r_st[r_rbank] <= w_rlast ? BANK_EMPTY : BANK_DRAINING;
    end
  end

  ilv_skid2 u_skid (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_re_d),
    .i_dat (mem_rdata),
    .o_vld (out_valid),
    .o_dat (out_data),
    .i_rdy (out_ready),
    .o_cnt (w_skid_cnt)
  );

`ifdef ILV_STATS_EN
  logic [15:0] r_blk_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_cnt   <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_re & w_rlast) r_blk_cnt <= r_blk_cnt + 1'b1;
      if (out_valid & ~out_ready & (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign blk_cnt   = r_blk_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ilv_pingpong_ctrl.sv
// Directed bench for ilv_pingpong_ctrl with a two-bank 1-cycle-latency memory model and an
// output collector; expected streams come from hand constants or the inverse permutation.
module tb_ilv_pingpong_ctrl;

  localparam int NB = 192;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_data;
  logic       in_ready;
  logic       mem_we;
  logic       mem_wbank;
  logic [7:0] mem_waddr;
  logic       mem_wdata;
  logic       mem_re;
  logic       mem_rbank;
  logic [7:0] mem_raddr;
  logic       mem_rdata;
  logic       out_valid;
  logic       out_data;
  logic       out_ready;
`ifdef ILV_STATS_EN
  logic [15:0] blk_cnt;
  logic [15:0] stall_cnt;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_conflict = 0;
  int   tx_idx = 0;
  logic tx_q[$];
  logic exp_q[$];
  logic got[$];
  logic bank_mem [2][256];

  ilv_pingpong_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_wbank (mem_wbank),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_rbank (mem_rbank),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef ILV_STATS_EN
    ,
    .blk_cnt   (blk_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) bank_mem[mem_wbank][mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= bank_mem[mem_rbank][mem_raddr];
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
    if (mem_we && mem_re && (mem_wbank == mem_rbank)) n_conflict++;
  end

  // Output bit j of a block is input bit 16*(j%12) + j/12
  task automatic load_random(input int nblk);
    tx_q.delete();
    exp_q.delete();
    got.delete();
    tx_idx = 0;
    for (int i = 0; i < nblk * NB; i++) tx_q.push_back(1'($urandom));
    for (int b = 0; b < nblk; b++)
      for (int j = 0; j < NB; j++) exp_q.push_back(tx_q[b*NB + 16*(j%12) + j/12]);
  endtask

  function automatic int blk_mism(input int b);
    int m = 0;
    for (int j = 0; j < NB; j++) begin
      if (b*NB + j >= got.size()) m++;
      else if (got[b*NB + j] !== exp_q[b*NB + j]) m++;
    end
    return m;
  endfunction

  task automatic drive_inputs(input int n, input int vpct);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(99) < vpct);
      in_data  = tx_q[tx_idx];
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) begin
        acc++;
        tx_idx++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++;
    if (acc !== n) $display("FAIL drive_inputs: accepted %0d bits, required %0d", acc, n);
    else n_pass++;
  endtask

  task automatic drive_ready(input int rpct, input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 30000) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n_chk++;
    if (got.size() < n) $display("FAIL drive_ready: collected %0d bits, required %0d", got.size(), n);
    else n_pass++;
  endtask

  task automatic wait_out(input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (got.size() < n) $display("FAIL wait_out: collected %0d bits, required %0d", got.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({in_ready, mem_we, mem_re, out_valid} !== 4'b0000)
      $display("FAIL reset_ctrl: rdy/we/re/vld=%b required 0000", {in_ready, mem_we, mem_re, out_valid});
    else n_pass++;
    n_chk++;
    if ({mem_wbank, mem_rbank, mem_waddr, mem_raddr} !== 18'd0)
      $display("FAIL reset_addr: banks/addrs=%h required 0", {mem_wbank, mem_rbank, mem_waddr, mem_raddr});
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL reset_release_early: in_ready=%b required 0", in_ready);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_rise: in_ready=%b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_permutation;
    int ks[6] = '{0, 1, 15, 16, 17, 191};
    int ea[6] = '{0, 12, 180, 1, 13, 191};
    int k = 0;
    int cyc = 0;
    int wb_bad = 0;
    load_random(1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = tx_q[0];
    while (k < NB && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) begin
        if (mem_wbank !== 1'b0) wb_bad++;
        for (int i = 0; i < 6; i++) begin
          if (k == ks[i]) begin
            n_chk++;
            if (mem_waddr !== 8'(ea[i])) $display("FAIL perm_k%0d: waddr=%0d required %0d", k, mem_waddr, ea[i]);
            else n_pass++;
          end
        end
        k++;
      end
      @(posedge clk); #1;
      in_valid = (k < NB);
      if (k < NB) in_data = tx_q[k];
    end
    n_chk++;
    if (wb_bad !== 0) $display("FAIL perm_wbank0: %0d writes not in bank 0, required 0", wb_bad);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({mem_wbank, mem_re, out_valid} !== 3'b110)
      $display("FAIL perm_t1: wbank/re/out_valid=%b required 110", {mem_wbank, mem_re, out_valid});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1) $display("FAIL perm_t2: out_valid=%b required 1", out_valid);
    else n_pass++;
    wait_out(NB);
    n_chk++;
    if (blk_mism(0) !== 0) $display("FAIL perm_data: %0d bad bits, required 0", blk_mism(0));
    else n_pass++;
  endtask

  task automatic test_end_to_end;
    logic [191:0] din;
    logic [191:0] dexp;
    logic [191:0] v;
    din  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    dexp = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
    tx_q.delete(); got.delete(); tx_idx = 0;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < NB; k++) tx_q.push_back(din[191-k]);
    out_ready = 1'b1;
    fork
      drive_inputs(2*NB, 100);
      wait_out(2*NB);
    join
    repeat (30) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      v = '0;
      for (int j = 0; j < NB; j++) if (b*NB + j < got.size()) v[191-j] = got[b*NB + j];
      n_chk++;
      if (v !== dexp) $display("FAIL e2e_blk%0d: got %h required %h", b, v, dexp);
      else n_pass++;
    end
    n_chk++;
    if (got.size() !== 2*NB) $display("FAIL e2e_beats: %0d beats required %0d", got.size(), 2*NB);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int  acc = 0;
    int  cyc = 0;
    int  hold = 0;
    int  leak = 0;
    int  early = -1;
    bit  fell_seen = 1'b0;
    load_random(3);
    out_ready = 1'b0;
    while ((acc < 3*NB || got.size() < 3*NB) && cyc < 5000) begin
      @(posedge clk); #1;
      if (hold == 20 && !out_ready) begin
        early = got.size();
        out_ready = 1'b1;
      end
      in_valid = (acc < 3*NB);
      if (acc < 3*NB) in_data = tx_q[acc];
      @(negedge clk);
      cyc++;
      if (acc == 2*NB && !out_ready) begin
        if (!fell_seen) begin
          n_chk++;
          if (in_ready !== 1'b0) $display("FAIL bp_fall: in_ready=%b required 0", in_ready);
          else n_pass++;
          fell_seen = 1'b1;
        end else if (in_ready) leak++;
        hold++;
      end
      if (in_valid && in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++;
    if (fell_seen !== 1'b1) $display("FAIL bp_stall_reached: seen=%b required 1", fell_seen);
    else n_pass++;
    n_chk++;
    if (leak !== 0) $display("FAIL bp_hold: in_ready high %0d cycles, required 0", leak);
    else n_pass++;
    n_chk++;
    if (early !== 0) $display("FAIL bp_no_output: %0d bits before release, required 0", early);
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      n_chk++;
      if (blk_mism(b) !== 0) $display("FAIL bp_blk%0d: %0d bad bits, required 0", b, blk_mism(b));
      else n_pass++;
    end
  endtask

  task automatic test_random;
    load_random(10);
    fork
      drive_inputs(10*NB, 70);
      drive_ready(50, 10*NB);
    join
    repeat (20) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      n_chk++;
      if (blk_mism(b) !== 0) $display("FAIL rnd_blk%0d: %0d bad bits, required 0", b, blk_mism(b));
      else n_pass++;
    end
    n_chk++;
    if (got.size() !== 10*NB) $display("FAIL rnd_beats: %0d beats required %0d", got.size(), 10*NB);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    load_random(2);
    out_ready = 1'b1;
    drive_inputs(NB + 100, 100);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({in_ready, mem_we, mem_re, out_valid, mem_wbank, mem_rbank, mem_waddr, mem_raddr} !== 22'd0)
      $display("FAIL rstmid_outputs: %h required 0",
               {in_ready, mem_we, mem_re, out_valid, mem_wbank, mem_rbank, mem_waddr, mem_raddr});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    load_random(1);
    fork
      drive_inputs(NB, 100);
      wait_out(NB);
    join
    repeat (30) @(negedge clk);
    n_chk++;
    if (blk_mism(0) !== 0) $display("FAIL rstmid_data: %0d bad bits, required 0", blk_mism(0));
    else n_pass++;
    n_chk++;
    if (got.size() !== NB) $display("FAIL rstmid_beats: %0d beats required %0d", got.size(), NB);
    else n_pass++;
  endtask

`ifdef ILV_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({blk_cnt, stall_cnt} !== 32'd0) $display("FAIL stats_reset: %h required 0", {blk_cnt, stall_cnt});
    else n_pass++;
    rst = 1'b0;
    load_random(3);
    out_ready = 1'b1;
    fork
      drive_inputs(3*NB, 100);
      begin
        wait_out(50);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_out(3*NB);
      end
    join
    repeat (10) @(negedge clk);
    n_chk++;
    if (blk_cnt !== 16'd3) $display("FAIL stats_blk: blk_cnt=%0d required 3", blk_cnt);
    else n_pass++;
    n_chk++;
    if (stall_cnt !== 16'd7) $display("FAIL stats_stall: stall_cnt=%0d required 7", stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_permutation();
    test_end_to_end();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef ILV_STATS_EN
    test_stats();
`endif
    n_chk++;
    if (n_conflict !== 0) $display("FAIL bank_conflict: %0d same-bank read+write cycles, required 0", n_conflict);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
